// File: rtl/gpr_file.sv
// General-purpose register file: 2^ADDR_WIDTH x DATA_WIDTH, x0 hardwired to zero.
// Two write ports share one enable; three combinational read ports plus a flat dump.
module gpr_file #(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 64
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic                                        wen,
    input  logic [DATA_WIDTH-1:0]                       wdata0,
    input  logic [ADDR_WIDTH-1:0]                       waddr0,
    input  logic [DATA_WIDTH-1:0]                       wdata1,
    input  logic [ADDR_WIDTH-1:0]                       waddr1,
    input  logic [ADDR_WIDTH-1:0]                       raddr_a,
    input  logic [ADDR_WIDTH-1:0]                       raddr_b,
    input  logic [ADDR_WIDTH-1:0]                       raddr_c,
    output logic [DATA_WIDTH-1:0]                       rdata_a,
    output logic [DATA_WIDTH-1:0]                       rdata_b,
    output logic [DATA_WIDTH-1:0]                       rdata_c,
    output logic [(1 << ADDR_WIDTH)*DATA_WIDTH-1:0]     regs_out
);

    localparam int unsigned NREG = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs_full [NREG];

    assign regs_full[0]               = '0;
    assign regs_out[DATA_WIDTH-1:0]   = '0;

    for (genvar i = 1; i < NREG; i++) begin : g_reg
        logic [DATA_WIDTH-1:0] reg_d;
        logic [DATA_WIDTH-1:0] reg_q;

        // Port 0 takes priority when both ports target the same register.
        always_comb begin
            reg_d = reg_q;
            if (wen) begin
                if (waddr0 == ADDR_WIDTH'(i)) begin
                    reg_d = wdata0;
                end else if (waddr1 == ADDR_WIDTH'(i)) begin
                    reg_d = wdata1;
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                reg_q <= '0;
            end else begin
                reg_q <= reg_d;
            end
        end

        assign regs_full[i]                             = reg_q;
        assign regs_out[i*DATA_WIDTH +: DATA_WIDTH]     = reg_q;
    end

    assign rdata_a = regs_full[raddr_a];
    assign rdata_b = regs_full[raddr_b];
    assign rdata_c = regs_full[raddr_c];

endmodule

// File: tb/tb_gpr_file.sv
// Randomised scoreboard bench for gpr_file against an array-based reference model.
module tb_gpr_file;

    localparam int AW = 5;
    localparam int DW = 64;
    localparam int NR = 1 << AW;

    logic              clk;
    logic              rst_n;
    logic              wen;
    logic [DW-1:0]     wdata0, wdata1;
    logic [AW-1:0]     waddr0, waddr1;
    logic [AW-1:0]     raddr_a, raddr_b, raddr_c;
    logic [DW-1:0]     rdata_a, rdata_b, rdata_c;
    logic [NR*DW-1:0]  regs_out;

    gpr_file #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wen      (wen),
        .wdata0   (wdata0),
        .waddr0   (waddr0),
        .wdata1   (wdata1),
        .waddr1   (waddr1),
        .raddr_a  (raddr_a),
        .raddr_b  (raddr_b),
        .raddr_c  (raddr_c),
        .rdata_a  (rdata_a),
        .rdata_b  (rdata_b),
        .rdata_c  (rdata_c),
        .regs_out (regs_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string          tag;
        logic [DW-1:0]  ea;
        logic [DW-1:0]  eb;
        logic [DW-1:0]  ec;
        logic [NR*DW-1:0] edump;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] model [NR];
    int            errors = 0;
    int            checks = 0;

    function automatic logic [NR*DW-1:0] model_dump();
        logic [NR*DW-1:0] d;
        for (int i = 0; i < NR; i++) d[i*DW +: DW] = model[i];
        return d;
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < NR; i++) model[i] = '0;
    endfunction

    task automatic push_exp(input string tag);
        exp_t e;
        e.tag   = tag;
        e.ea    = model[raddr_a];
        e.eb    = model[raddr_b];
        e.ec    = model[raddr_c];
        e.edump = model_dump();
        exp_q.push_back(e);
    endtask

    // Monitor: outputs are combinational, sampled mid-cycle at the falling edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks += 4;
            if (rdata_a !== e.ea) begin
                errors++;
                $display("FAIL %s rdata_a: got %h want %h", e.tag, rdata_a, e.ea);
            end
            if (rdata_b !== e.eb) begin
                errors++;
                $display("FAIL %s rdata_b: got %h want %h", e.tag, rdata_b, e.eb);
            end
            if (rdata_c !== e.ec) begin
                errors++;
                $display("FAIL %s rdata_c: got %h want %h", e.tag, rdata_c, e.ec);
            end
            if (regs_out !== e.edump) begin
                errors++;
                for (int i = 0; i < NR; i++)
                    if (regs_out[i*DW +: DW] !== e.edump[i*DW +: DW])
                        $display("FAIL %s regs_out[%0d]: got %h want %h", e.tag, i,
                                 regs_out[i*DW +: DW], e.edump[i*DW +: DW]);
            end
        end
    end

    // One clock cycle: drive inputs after the edge, expect pre-write state mid-cycle,
    // then apply the write to the model at the next rising edge.
    task automatic cycle(input logic w, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                         input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                         input logic [AW-1:0] ra, input logic [AW-1:0] rb,
                         input logic [AW-1:0] rc, input string tag);
        wen = w; waddr0 = a0; wdata0 = d0; waddr1 = a1; wdata1 = d1;
        raddr_a = ra; raddr_b = rb; raddr_c = rc;
        push_exp(tag);
        @(posedge clk);
        if (rst_n && w) begin
            if (a1 != 0) model[a1] = d1;
            if (a0 != 0) model[a0] = d0;
        end
        #1;
    endtask

    task automatic idle_read(input logic [AW-1:0] ra, input logic [AW-1:0] rb,
                             input logic [AW-1:0] rc, input string tag);
        cycle(1'b0, '0, '0, '0, '0, ra, rb, rc, tag);
    endtask

    initial begin
        rst_n = 1'b0;
        wen = 1'b0; wdata0 = '0; wdata1 = '0; waddr0 = '0; waddr1 = '0;
        raddr_a = '0; raddr_b = '0; raddr_c = '0;
        model_clear();

        @(posedge clk); #1;
        cycle(1'b1, 5'd4, 64'hFFFF, 5'd6, 64'h1234, 5'd4, 5'd6, 5'd0, "reset_hold");
        rst_n = 1'b1;
        idle_read(5'd4, 5'd6, 5'd1, "reset_release");

        // Write then asynchronous reset with no intervening clock edge.
        cycle(1'b1, 5'd5, 64'hDEAD_BEEF, 5'd0, '0, 5'd5, 5'd5, 5'd5, "pre_write5");
        idle_read(5'd5, 5'd0, 5'd5, "wrote5");
        raddr_a = 5'd5;
        rst_n = 1'b0;
        model_clear();
        push_exp("async_reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle_read(5'd5, 5'd5, 5'd5, "after_reset");

        // Basic write, with old value visible before the edge.
        cycle(1'b1, 5'd3, 64'h0123_4567_89AB_CDEF, 5'd0, '0, 5'd3, 5'd3, 5'd3, "before_edge3");
        idle_read(5'd3, 5'd3, 5'd3, "basic3");

        // Register zero on both ports.
        cycle(1'b1, 5'd0, '1, 5'd0, 64'd5, 5'd0, 5'd0, 5'd0, "zero_write");
        idle_read(5'd0, 5'd3, 5'd0, "zero_read");

        // Dual port, then collision.
        cycle(1'b1, 5'd1, 64'h11, 5'd2, 64'h22, 5'd1, 5'd2, 5'd0, "dual");
        idle_read(5'd1, 5'd2, 5'd3, "dual_read");
        cycle(1'b1, 5'd7, 64'hAA, 5'd7, 64'hBB, 5'd7, 5'd0, 5'd7, "collide");
        idle_read(5'd7, 5'd7, 5'd7, "collide_read");

        // wen low holds state.
        cycle(1'b1, 5'd10, 64'h42, 5'd0, '0, 5'd0, 5'd0, 5'd10, "set10");
        for (int i = 0; i < 4; i++)
            cycle(1'b0, 5'd10, 64'h99, 5'd11, 64'h77, 5'd11, 5'd10, 5'd10, "wen_low");
        idle_read(5'd10, 5'd11, 5'd10, "wen_low_end");

        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            cycle(1'($urandom_range(0, 1)), AW'($urandom), {$urandom, $urandom},
                  AW'($urandom), {$urandom, $urandom},
                  AW'($urandom), AW'($urandom), AW'($urandom), "random");
        end

        // Full sweep.
        for (int i = 1; i < NR; i++)
            cycle(1'b1, AW'(i), DW'(i) * 64'h0101_0101_0101_0101, 5'd0, '0,
                  AW'(i), 5'd0, 5'd10, "sweep_write");
        for (int i = 0; i < NR; i++)
            idle_read(AW'(i), AW'(i), AW'(NR - 1 - i), "sweep_read");

        for (int t = 0; t < 10 && exp_q.size() > 0; t++) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
